alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered result stage downstream of the 4-bit ALU output multiplexer.
//  - Captures the selected 4-bit ALU result and Opcode[3:2] class, computes status flags, and buffers entries in a DEPTH-entry FIFO.
//  - Presents buffered entries to the writeback/consumer via valid/ready.
//  - Decouples ALU issue from consumer stalls.
// PARAMETERS
//  DEPTH  2  FIFO entries; legal range 1..8; need not be a power of 2
//  CW     2  count/pointer helper width; must equal clog2(DEPTH+1)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  ALU result valid this cycle
//  in_ready   out  1  stage can accept; = (count != DEPTH)
//  alu_out    in   4  selected ALU result (multiplexer Out)
//  opcode     in   2  Opcode[3:2]: 00 shift, 01 arith, 10 logical, 11 compare
//  res_valid  out  1  head entry available; = (count != 0)
//  res_ready  in   1  consumer accepts head entry
//  res_data   out  4  head result; 4'h0 when empty
//  res_class  out  2  head opcode class; 2'b00 when empty
//  res_zero   out  1  head result == 0; 0 when empty
//  res_neg    out  1  head result[3]; 0 when empty
//  res_par    out  1  XOR-reduction of head result (odd parity); 0 when empty
//  cmp_flag   out  1  sticky: alu_out[0] of most recent pushed compare-class entry
//  count      out  CW number of valid entries
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous):
//    - count=0; rd/wr pointers=0; storage cleared; cmp_flag=0.
//    - Hence res_valid=0, in_ready=1, and all res_* outputs are 0.
//    - Reset mid-transfer discards all entries immediately; no partial state survives.
//  - Push = in_valid & in_ready. Stores {opcode, alu_out, zero, neg, par}.
//    - Flags are computed from alu_out at push time.
//  - Pop = res_valid & res_ready. Advances rd pointer.
//  - Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
//  - Count update:
//    - +1 on push only; -1 on pop only; unchanged on push&pop.
//  - Latency: no bypass.
//    - Entry pushed in cycle N is visible on res_* in cycle N+1 at the earliest.
//  - Full (count==DEPTH): in_ready=0.
//    - An in_valid is ignored: not stored, no flag update. The upstream holds.
//    - A pop while full does not enable a push in the same cycle; in_ready rises the next cycle.
//  - Empty (count==0): res_valid=0; res_ready is ignored; no pointer change.
//  - Simultaneous push & pop with 0<count<DEPTH:
//    - Both pointers advance; count unchanged; the popped entry is the old head.
//  - cmp_flag updates only on a push with opcode==2'b11, and takes alu_out[0].
//    - Other pushes and all pops leave it unchanged.
//  - res_* outputs come from the head storage entry, forced to 0 when count==0. There is no combinational path from in_* to res_*.
//  - in_ready depends only on registered count; no combinational path from res_ready to in_ready.
//  - DEPTH=1 is legal: single register, alternating push/pop, max throughput 1 per 2 cycles.
// TESTING
//  1. Reset mid-operation:
//     - Stimulus: assert rst_n=0 asynchronously with count=2.
//     - Response: res_valid=0, in_ready=1, count=0, cmp_flag=0 before the next clk edge.
//  2. Single push, then pop:
//     - Stimulus: push alu_out=4'b0000, opcode=01 at cycle N.
//     - Response: cycle N+1 shows res_valid=1, res_data=0, res_class=01, zero=1, neg=0, par=0.
//     - Then res_ready=1 -> count=0.
//  3. Fill to full (DEPTH=2) and hold:
//     - Stimulus: push 4'h3 then 4'hB with res_ready=0, then hold in_valid=1 with 4'h5.
//     - Response after the fill: in_ready=0, count=2, 4'h5 not stored.
//     - Pops return 3 then B; B has neg=1, par=1.
//  4. Simultaneous push & pop at count=1, ten consecutive cycles:
//     - Response: count stays 1; outputs appear in order; pointers wrap correctly.
//  5. Compare sticky:
//     - Stimulus: push opcode=11 with alu_out=4'h1, then opcode=00 with 4'hE.
//     - Response: cmp_flag=1 after the first push and remains 1.
//     - A later compare push of 4'h0 -> cmp_flag=0.
//  6. Pop while full:
//     - Response: in_ready=0 in that cycle, 1 in the next.
//     - A push offered in the pop cycle is not accepted.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU output multiplexer: buffers results with
// their status flags in a DEPTH-entry FIFO and hands them to writeback over valid/ready.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_out,
    input  logic [1:0]    opcode,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_data,
    output logic [1:0]    res_class,
    output logic          res_zero,
    output logic          res_neg,
    output logic          res_par,
    output logic          cmp_flag,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

    function automatic logic calc_par(input logic [3:0] d);
        return ^d;
    endfunction

    // Entry layout: {class[1:0], data[3:0], zero, neg, par}
    function automatic logic [8:0] pack_entry(input logic [1:0] op, input logic [3:0] d);
        return {op, d, (d == 4'h0), d[3], calc_par(d)};
    endfunction

    logic [8:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmp_flag_q, cmp_flag_d;
    logic          push_s, pop_s;
    logic [8:0]    head_s;

    // in_ready is driven from registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready  = (count_q != FULL_C);
    assign res_valid = (count_q != {CW{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = res_valid & res_ready;

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        head_s = 9'h000;
        if (res_valid) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = 9'h000;
        end
    end

    assign res_class = head_s[8:7];
    assign res_data  = head_s[6:3];
    assign res_zero  = head_s[2];
    assign res_neg   = head_s[1];
    assign res_par   = head_s[0];
    assign cmp_flag  = cmp_flag_q;
    assign count     = count_q;

    // Next-state for pointers, occupancy count and the sticky compare flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cmp_flag_d = cmp_flag_q;
        count_d    = count_q;
        if (push_s) begin
            if (wr_ptr_q == LAST_C) begin
                wr_ptr_d = {PW{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (opcode == 2'b11) begin
                cmp_flag_d = alu_out[0];
            end else begin
                cmp_flag_d = cmp_flag_q;
            end
        end else begin
            wr_ptr_d   = wr_ptr_q;
            cmp_flag_d = cmp_flag_q;
        end
        if (pop_s) begin
            if (rd_ptr_q == LAST_C) begin
                rd_ptr_d = {PW{1'b0}};
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            cmp_flag_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmp_flag_q <= cmp_flag_d;
        end
    end

    // Entry storage; flags are computed once, when the result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (wr_ptr_q == PW'(i))) begin
                    mem_q[i] <= pack_entry(opcode, alu_out);
                end else begin
                    mem_q[i] <= mem_q[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_alu_result_stage;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_out;
    logic [1:0]    opcode;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_data;
    logic [1:0]    res_class;
    logic          res_zero;
    logic          res_neg;
    logic          res_par;
    logic          cmp_flag;
    logic [CW-1:0] count;

    alu_result_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .opcode(opcode), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_class(res_class), .res_zero(res_zero), .res_neg(res_neg),
        .res_par(res_par), .cmp_flag(cmp_flag), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] c;
    } ent_t;

    ent_t q[$];
    logic cmp_m;
    int   n_assert;
    int   n_fail;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_par(input logic [3:0] d);
        int ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic check_all(input string where);
        logic [3:0] ed;
        logic [1:0] ec;
        ed = 4'h0;
        ec = 2'b00;
        if (q.size() != 0) begin
            ed = q[0].d;
            ec = q[0].c;
        end
        chk({where, ":res_valid"}, {7'd0, res_valid}, {7'd0, q.size() != 0});
        chk({where, ":in_ready"},  {7'd0, in_ready},  {7'd0, q.size() != DEPTH});
        chk({where, ":count"},     {6'd0, count},     8'(q.size()));
        chk({where, ":cmp_flag"},  {7'd0, cmp_flag},  {7'd0, cmp_m});
        chk({where, ":res_data"},  {4'd0, res_data},  {4'd0, ed});
        chk({where, ":res_class"}, {6'd0, res_class}, {6'd0, ec});
        chk({where, ":res_zero"},  {7'd0, res_zero},  {7'd0, (q.size() != 0) && (ed == 4'd0)});
        chk({where, ":res_neg"},   {7'd0, res_neg},   {7'd0, (q.size() != 0) && (ed >= 4'd8)});
        chk({where, ":res_par"},   {7'd0, res_par},   {7'd0, (q.size() != 0) && model_par(ed)});
    endtask

    // One clock: drive inputs, check current outputs, advance model across the edge.
    task automatic cycle(input string where, input logic v, input logic [3:0] d,
                         input logic [1:0] op, input logic rr);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        alu_out   = d;
        opcode    = op;
        res_ready = rr;
        #1;
        check_all(where);
        do_push = v && (q.size() != DEPTH);
        do_pop  = rr && (q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back('{d: d, c: op});
            if (op == 2'b11) cmp_m = d[0];
        end
        #2;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cmp_m     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_out   = 4'h0;
        opcode    = 2'b00;
        res_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        check_all("reset");

        // Reset mid-operation with two entries and cmp_flag set.
        cycle("t1_fill0", 1'b1, 4'h1, 2'b11, 1'b0);
        cycle("t1_fill1", 1'b1, 4'h6, 2'b10, 1'b0);
        cycle("t1_full",  1'b0, 4'h0, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        q.delete();
        cmp_m = 1'b0;
        check_all("t1_async_rst");
        #1;
        rst_n = 1'b1;

        // Single push then pop.
        cycle("t2_push", 1'b1, 4'h0, 2'b01, 1'b0);
        cycle("t2_pop",  1'b0, 4'h0, 2'b00, 1'b1);
        cycle("t2_idle", 1'b0, 4'h0, 2'b00, 1'b1);

        // Fill to full and hold 4'h5 upstream; then drain.
        cycle("t3_p3",    1'b1, 4'h3, 2'b00, 1'b0);
        cycle("t3_pB",    1'b1, 4'hB, 2'b01, 1'b0);
        cycle("t3_hold0", 1'b1, 4'h5, 2'b10, 1'b0);
        cycle("t3_hold1", 1'b1, 4'h5, 2'b10, 1'b0);
        chk("t3_head_is_3", {4'd0, res_data}, 8'h03);
        cycle("t3_pop3",  1'b0, 4'h0, 2'b00, 1'b1);
        chk("t3_head_is_B", {4'd0, res_data}, 8'h0B);
        chk("t3_B_neg_par", {6'd0, res_neg, res_par}, 8'h03);
        cycle("t3_popB",  1'b0, 4'h0, 2'b00, 1'b1);

        // Ten cycles of simultaneous push & pop at count=1.
        cycle("t4_prime", 1'b1, 4'h9, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("t4_pushpop", 1'b1, 4'($urandom), 2'($urandom), 1'b1);
        end
        cycle("t4_drain", 1'b0, 4'h0, 2'b00, 1'b1);

        // Compare sticky flag.
        cycle("t5_cmp1",  1'b1, 4'h1, 2'b11, 1'b1);
        cycle("t5_shift", 1'b1, 4'hE, 2'b00, 1'b1);
        chk("t5_sticky", {7'd0, cmp_flag}, 8'h01);
        cycle("t5_cmp0",  1'b1, 4'h0, 2'b11, 1'b1);
        cycle("t5_chk",   1'b0, 4'h0, 2'b00, 1'b1);
        chk("t5_cleared", {7'd0, cmp_flag}, 8'h00);
        cycle("t5_drain", 1'b0, 4'h0, 2'b00, 1'b1);

        // Pop while full with a push offered: push must not be accepted.
        cycle("t6_f0",  1'b1, 4'h2, 2'b00, 1'b0);
        cycle("t6_f1",  1'b1, 4'h4, 2'b00, 1'b0);
        chk("t6_full_in_ready", {7'd0, in_ready}, 8'h00);
        cycle("t6_pop_full", 1'b1, 4'h7, 2'b11, 1'b1);
        chk("t6_next_in_ready", {7'd0, in_ready}, 8'h01);
        chk("t6_next_count", {6'd0, count}, 8'h01);
        chk("t6_no_cmp", {7'd0, cmp_flag}, 8'h00);
        cycle("t6_d0", 1'b0, 4'h0, 2'b00, 1'b1);
        cycle("t6_d1", 1'b0, 4'h0, 2'b00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
        end
        cycle("final", 1'b0, 4'h0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
